prefix_add_sequencer: RTL and testbench

Sequences one shared SLICE_W-bit parallel-prefix adder, built from black/gray cells, so it can add or subtract DATA_W-bit operands. Operands are processed over DATA_W/SLICE_W consecutive cycles, with the carry chained through a register between slices. The block sits in the vector unit between the issue logic (valid/ready request) and the writeback stage (valid/ready response). The adder is an external instance: this block drives its inputs and samples its outputs combinationally in the same cycle.

---
 rtl/prefix_add_pkg.sv | 23 ++
 rtl/prefix_slice_mux.sv | 34 +++
 rtl/prefix_add_sequencer.sv | 128 ++++++++++++
 tb/tb_prefix_add_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_add_pkg.sv
// Shared definitions for the prefix-adder sequencer: FSM encodings,
// default slice width and a constant-foldable clog2.
package prefix_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SLICE_W_DEFAULT = 64;

  // Number of bits needed to index 'value' distinct items (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prefix_slice_mux.sv
// Selects slice 'idx' of the held operands for the shared adder.
// Outputs are forced to zero when 'en' is low so the adder inputs are
// quiet whenever no slice is being processed.
module prefix_slice_mux
  import prefix_add_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int SLICE_W    = SLICE_W_DEFAULT,
  parameter int NUM_SLICES = DATA_W / SLICE_W,
  parameter int IDX_W      = clog2(NUM_SLICES)
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [SLICE_W-1:0] a_slice,
  output logic [SLICE_W-1:0] b_slice
);

  // Decoded slice select; constant part-selects keep every index in range.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    if (en) begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        if (idx == IDX_W'(i)) begin
          a_slice = a[i*SLICE_W +: SLICE_W];
          b_slice = b[i*SLICE_W +: SLICE_W];
        end
      end
    end
  end

endmodule

// File: rtl/prefix_add_sequencer.sv
// Multi-cycle DATA_W add/subtract built on one external SLICE_W prefix
// adder. Slices are processed LSB first; the carry is chained through 'cy'.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The request side is ready in IDLE, or in DONE when the current
// result is being consumed in the same cycle (back-to-back issue); flush_i
// forces ready low. The response side holds valid and data stable until
// resp_ready_i is seen.
module prefix_add_sequencer
  import prefix_add_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int SLICE_W = SLICE_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [DATA_W-1:0]  req_a_i,
  input  logic [DATA_W-1:0]  req_b_i,
  input  logic               req_sub_i,
  input  logic               req_cin_i,
  output logic [SLICE_W-1:0] add_a_o,
  output logic [SLICE_W-1:0] add_b_o,
  output logic               add_cin_o,
  input  logic [SLICE_W-1:0] add_sum_i,
  input  logic               add_cout_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [DATA_W-1:0]  resp_sum_o,
  output logic               resp_cout_o,
  output logic               resp_ovf_o,
  output logic               busy_o
);

  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int IDX_W      = clog2(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  idx;
  logic              cy;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] sum_q;
  logic              accept;
  logic              running;
  logic              last_slice;

  assign accept     = req_valid_i & req_ready_o;
  assign running    = (state == S_RUN);
  assign last_slice = (idx == LAST_IDX);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; flush abandons whatever is in flight.
  always_comb begin
    next_state = state;
    if (flush_i) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) next_state = S_RUN;
        S_RUN:   if (last_slice) next_state = S_DONE;
        S_DONE:  if (resp_ready_i) next_state = accept ? S_RUN : S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // FSM-derived handshake and status outputs.
  always_comb begin
    req_ready_o  = ~flush_i & ((state == S_IDLE) | ((state == S_DONE) & resp_ready_i));
    resp_valid_o = (state == S_DONE);
    busy_o       = (state != S_IDLE);
  end

  // Operand capture, per-slice sum write-back and carry chaining.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx   <= '0;
      cy    <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else if (flush_i) begin
      idx <= '0;
    end else if (accept) begin
      a_q <= req_a_i;
      b_q <= req_sub_i ? ~req_b_i : req_b_i;
      cy  <= req_sub_i ? 1'b1 : req_cin_i;
      idx <= '0;
    end else if (running) begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        if (idx == IDX_W'(i)) sum_q[i*SLICE_W +: SLICE_W] <= add_sum_i;
      end
      cy  <= add_cout_i;
      idx <= last_slice ? '0 : idx + 1'b1;
    end
  end

  prefix_slice_mux #(
    .DATA_W     (DATA_W),
    .SLICE_W    (SLICE_W),
    .NUM_SLICES (NUM_SLICES),
    .IDX_W      (IDX_W)
  ) u_slice_mux (
    .a       (a_q),
    .b       (b_q),
    .idx     (idx),
    .en      (running),
    .a_slice (add_a_o),
    .b_slice (add_b_o)
  );

  assign add_cin_o   = running & cy;
  assign resp_sum_o  = sum_q;
  assign resp_cout_o = cy;
  // b_q already holds the effective operand, so one rule covers add and sub.
  assign resp_ovf_o  = (a_q[DATA_W-1] == b_q[DATA_W-1]) & (sum_q[DATA_W-1] != a_q[DATA_W-1]);

endmodule

// File: tb/tb_prefix_add_sequencer.sv
// Bench for prefix_add_sequencer with a behavioural slice adder attached.
module tb_prefix_add_sequencer;

  localparam int DATA_W  = 256;
  localparam int SLICE_W = 64;
  localparam int NS      = DATA_W / SLICE_W;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic               flush_i = 1'b0;
  logic               req_valid_i = 1'b0;
  logic               req_ready_o;
  logic [DATA_W-1:0]  req_a_i = '0;
  logic [DATA_W-1:0]  req_b_i = '0;
  logic               req_sub_i = 1'b0;
  logic               req_cin_i = 1'b0;
  logic [SLICE_W-1:0] add_a_o;
  logic [SLICE_W-1:0] add_b_o;
  logic               add_cin_o;
  logic [SLICE_W-1:0] add_sum_i;
  logic               add_cout_i;
  logic               resp_valid_o;
  logic               resp_ready_i = 1'b0;
  logic [DATA_W-1:0]  resp_sum_o;
  logic               resp_cout_o;
  logic               resp_ovf_o;
  logic               busy_o;

  int errors = 0;
  int checks = 0;
  logic cin_log [NS];

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // External slice adder: plain behavioural sum.
  assign {add_cout_i, add_sum_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {{SLICE_W{1'b0}}, add_cin_o};

  prefix_add_sequencer #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_sub_i    (req_sub_i),
    .req_cin_i    (req_cin_i),
    .add_a_o      (add_a_o),
    .add_b_o      (add_b_o),
    .add_cin_o    (add_cin_o),
    .add_sum_i    (add_sum_i),
    .add_cout_i   (add_cout_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_sum_o   (resp_sum_o),
    .resp_cout_o  (resp_cout_o),
    .resp_ovf_o   (resp_ovf_o),
    .busy_o       (busy_o)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic; returns {ovf, cout, sum}.
  function automatic logic [DATA_W+1:0] model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic sub, input logic cin);
    logic [DATA_W:0] u;
    logic [DATA_W:0] r;
    logic            cout;
    if (sub) begin
      u    = {1'b0, a} - {1'b0, b};
      cout = (a >= b);
      r    = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    end else begin
      u    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
      cout = u[DATA_W];
      r    = {a[DATA_W-1], a} + {b[DATA_W-1], b} + {{DATA_W{1'b0}}, cin};
    end
    return {r[DATA_W] ^ r[DATA_W-1], cout, u[DATA_W-1:0]};
  endfunction

  task automatic check_resp(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic sub, input logic cin);
    logic [DATA_W+1:0] e;
    e = model(a, b, sub, cin);
    chk({tag, "_valid"}, DATA_W'(resp_valid_o), DATA_W'(1'b1));
    chk({tag, "_sum"},   resp_sum_o,            e[DATA_W-1:0]);
    chk({tag, "_cout"},  DATA_W'(resp_cout_o),  DATA_W'(e[DATA_W]));
    chk({tag, "_ovf"},   DATA_W'(resp_ovf_o),   DATA_W'(e[DATA_W+1]));
  endtask

  // ---------------- drivers ----------------
  // Present a request and return #1 after the accepting edge.
  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic sub, input logic cin);
    int n;
    req_a_i = a; req_b_i = b; req_sub_i = sub; req_cin_i = cin; req_valid_i = 1'b1;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 20) chk("accept_timeout", DATA_W'(0), DATA_W'(1));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  // Count edges from the accept edge until resp_valid_o, logging add_cin_o.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (resp_valid_o !== 1'b1 && lat < 20) begin
      if (lat < NS) cin_log[lat] = add_cin_o;
      @(posedge clk_i); #1; lat++;
    end
  endtask

  task automatic consume();
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic sub, input logic cin);
    int lat;
    send(a, b, sub, cin);
    wait_resp(lat);
    chk({tag, "_latency"}, DATA_W'(lat), DATA_W'(NS));
    check_resp(tag, a, b, sub, cin);
    consume();
    chk({tag, "_idle_after"}, DATA_W'(busy_o), DATA_W'(1'b0));
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 5))
      0: w = '0;
      1: w = '1;
      2: w[DATA_W-1] = ~w[DATA_W-1];
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [DATA_W-1:0] a, b, a2, b2, held_sum;
    logic sub, cin, saw_valid;
    int lat;

    // Reset
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_req_ready",  DATA_W'(req_ready_o),  DATA_W'(1'b1));
    chk("rst_resp_valid", DATA_W'(resp_valid_o), DATA_W'(1'b0));
    chk("rst_resp_sum",   resp_sum_o,            '0);
    chk("rst_resp_cout",  DATA_W'(resp_cout_o),  DATA_W'(1'b0));
    chk("rst_resp_ovf",   DATA_W'(resp_ovf_o),   DATA_W'(1'b0));
    chk("rst_busy",       DATA_W'(busy_o),       DATA_W'(1'b0));
    chk("rst_add_a",      DATA_W'(add_a_o),      '0);
    chk("rst_add_b",      DATA_W'(add_b_o),      '0);
    chk("rst_add_cin",    DATA_W'(add_cin_o),    DATA_W'(1'b0));

    // Carry chain across slice 0 -> 1
    a = '0; a[SLICE_W-1:0] = '1;
    b = DATA_W'(1);
    send(a, b, 1'b0, 1'b0);
    wait_resp(lat);
    chk("carry_latency", DATA_W'(lat), DATA_W'(NS));
    chk("carry_cin_slice0", DATA_W'(cin_log[0]), DATA_W'(1'b0));
    chk("carry_cin_slice1", DATA_W'(cin_log[1]), DATA_W'(1'b1));
    chk("carry_sum_const", resp_sum_o, DATA_W'(1) << SLICE_W);
    check_resp("carry", a, b, 1'b0, 1'b0);
    consume();

    // Subtract with borrow
    send('0, DATA_W'(1), 1'b1, 1'b0);
    wait_resp(lat);
    chk("borrow_latency", DATA_W'(lat), DATA_W'(NS));
    chk("borrow_cin_first", DATA_W'(cin_log[0]), DATA_W'(1'b1));
    chk("borrow_sum_const", resp_sum_o, '1);
    check_resp("borrow", '0, DATA_W'(1), 1'b1, 1'b0);
    consume();

    // Signed overflow
    a = '1; a[DATA_W-1] = 1'b0;
    run_op("ovf", a, DATA_W'(1), 1'b0, 1'b0);
    chk("ovf_flag_const", DATA_W'(resp_ovf_o), DATA_W'(1'b1));

    // Backpressure then back-to-back accept on the consuming edge
    a = rand_word(); b = rand_word();
    a2 = rand_word(); b2 = rand_word();
    send(a, b, 1'b1, 1'b0);
    wait_resp(lat);
    chk("bp_latency", DATA_W'(lat), DATA_W'(NS));
    held_sum = resp_sum_o;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("bp_hold_sum", resp_sum_o, held_sum);
      check_resp("bp_hold", a, b, 1'b1, 1'b0);
    end
    req_a_i = a2; req_b_i = b2; req_sub_i = 1'b0; req_cin_i = 1'b1;
    req_valid_i = 1'b1; resp_ready_i = 1'b1;
    #1;
    chk("b2b_req_ready", DATA_W'(req_ready_o), DATA_W'(1'b1));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; resp_ready_i = 1'b0;
    chk("b2b_busy", DATA_W'(busy_o), DATA_W'(1'b1));
    wait_resp(lat);
    chk("b2b_latency", DATA_W'(lat), DATA_W'(NS));
    check_resp("b2b", a2, b2, 1'b0, 1'b1);
    consume();

    // Flush in the second RUN cycle
    send(rand_word(), rand_word(), 1'b0, 1'b0);
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    chk("flush_busy", DATA_W'(busy_o), DATA_W'(1'b0));
    req_valid_i = 1'b1;
    #1;
    chk("flush_req_ready_low", DATA_W'(req_ready_o), DATA_W'(1'b0));
    req_valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("flush_req_ready_back", DATA_W'(req_ready_o), DATA_W'(1'b1));
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      if (resp_valid_o !== 1'b0) saw_valid = 1'b1;
    end
    chk("flush_no_resp", DATA_W'(saw_valid), DATA_W'(1'b0));
    run_op("after_flush", DATA_W'(3), DATA_W'(5), 1'b0, 1'b0);
    chk("after_flush_sum", resp_sum_o, DATA_W'(8));

    // Randomized operations
    for (int i = 0; i < 20; i++) begin
      a = rand_word(); b = rand_word();
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      run_op("rand", a, b, sub, cin);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
